fdd_mech: RTL

- Parametrised mechanical model of 1..N Shugart-style floppy drives: head position, stepping, motor spin-up, index pulses, write-protect and ready.
- Successor to the fixed 4-drive mechanics inside fdd. Drive count, track count and timing are parameters; step-rate enforcement and spin-up delay are new.
- Sits between the FDC bus-side signals (USEL/MOTORn/STEPn/SDIRn/SIDEn) and the sector/SD engine, which consumes `track` and `side`.

---
 rtl/fdd_mech.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fdd_mech.sv
// rtl/fdd_mech.sv - mechanical model of 1..DRIVES Shugart-style floppy drives
// Optional disk-change latch built only when FDD_DISKCHANGE_EN is defined.
module fdd_mech #(
  parameter int DRIVES    = 4,
  parameter int TRACKS    = 80,
  parameter int CLK_KHZ   = 21477,
  parameter int STEP_MS   = 3,
  parameter int SPINUP_MS = 500,
  parameter int ROT_MS    = 200,
  parameter int INDEX_MS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(DRIVES)-1:0] usel,
  input  logic                      motor_n,
  input  logic                      step_n,
  input  logic                      sdir_n,
  input  logic                      side_n,
  input  logic [DRIVES-1:0]         img_mounted,
  input  logic [63:0]               img_size,
  input  logic                      img_readonly,
  output logic [6:0]                track,
  output logic                      side,
  output logic                      track0_n,
  output logic                      index_n,
  output logic                      ready_n,
  output logic                      wprot_n,
  output logic                      dskchg_n,
  output logic                      step_busy
);
  localparam int DW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
  localparam int TW = $clog2(STEP_MS + 1);
  localparam int SW = $clog2(SPINUP_MS + 1);
  localparam int RW = (ROT_MS > 1) ? $clog2(ROT_MS) : 1;
  localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_KHZ - 1);
  localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_MS);
  localparam logic [SW-1:0] SPIN_MAX  = SW'(SPINUP_MS);
  localparam logic [RW-1:0] ROT_LAST  = RW'(ROT_MS - 1);
  localparam logic [RW-1:0] IDX_END   = RW'(INDEX_MS);
  localparam logic [6:0]    TRK_MAX   = 7'(TRACKS - 1);

  logic [DW-1:0]     div;
  logic              tick;
  logic [2:0]        step_sync;
  logic              step_fall;
  logic [DRIVES-1:0] step_hit;
  logic [DRIVES-1:0] mnt_q;
  logic [DRIVES-1:0] present;
  logic [DRIVES-1:0] ro;
  logic [6:0]        trk      [DRIVES];
  logic [TW-1:0]     step_tmr [DRIVES];
  logic [SW-1:0]     spin     [DRIVES];
  logic [RW-1:0]     rot      [DRIVES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div  <= DIV_LOAD;
      tick <= 1'b0;
    end else if (div == '0) begin
      div  <= DIV_LOAD;
      tick <= 1'b1;
    end else begin
      div  <= div - DW'(1);
      tick <= 1'b0;
    end
  end

  // Idle-high reset value keeps release from looking like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_sync <= 3'b111;
    else       step_sync <= {step_sync[1:0], step_n};
  end

  assign step_fall = step_sync[2] & ~step_sync[1];
  assign step_hit  = {{(DRIVES-1){1'b0}}, step_fall} << usel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mnt_q   <= '0;
      present <= '0;
      ro      <= '1;
      for (int i = 0; i < DRIVES; i++) begin
        trk[i]      <= '0;
        step_tmr[i] <= '0;
        spin[i]     <= '0;
        rot[i]      <= '0;
      end
    end else begin
      mnt_q <= img_mounted;
      for (int i = 0; i < DRIVES; i++) begin
        if (img_mounted[i] && !mnt_q[i]) begin
          present[i] <= (img_size != 64'd0);
          ro[i]      <= img_readonly;
        end
        // A step at either end stop still consumes the step window.
        if (step_hit[i] && step_tmr[i] == '0) begin
          step_tmr[i] <= STEP_LOAD;
          if (!sdir_n && trk[i] != TRK_MAX)   trk[i] <= trk[i] + 7'd1;
          else if (sdir_n && trk[i] != 7'd0)  trk[i] <= trk[i] - 7'd1;
        end else if (tick && step_tmr[i] != '0) begin
          step_tmr[i] <= step_tmr[i] - TW'(1);
        end
        if (motor_n)                          spin[i] <= '0;
        else if (tick && spin[i] != SPIN_MAX) spin[i] <= spin[i] + SW'(1);
        if (!motor_n && tick)
          rot[i] <= (rot[i] == ROT_LAST) ? '0 : rot[i] + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      track     <= '0;
      side      <= 1'b0;
      track0_n  <= 1'b0;
      index_n   <= 1'b1;
      ready_n   <= 1'b1;
      wprot_n   <= 1'b0;
      step_busy <= 1'b0;
    end else begin
      track     <= trk[usel];
      side      <= ~side_n;
      track0_n  <= (trk[usel] != 7'd0);
      index_n   <= ~(present[usel] && !motor_n && rot[usel] < IDX_END);
      ready_n   <= ~(present[usel] && spin[usel] == SPIN_MAX);
      wprot_n   <= present[usel] && !ro[usel];
      step_busy <= (step_tmr[usel] != '0);
    end
  end

`ifdef FDD_DISKCHANGE_EN
  logic [DRIVES-1:0] chg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chg      <= '1;
      dskchg_n <= 1'b0;
    end else begin
      for (int i = 0; i < DRIVES; i++) begin
        if (img_mounted[i] != mnt_q[i])
          chg[i] <= 1'b1;
        else if (step_hit[i] && step_tmr[i] == '0 && present[i])
          chg[i] <= 1'b0;
      end
      dskchg_n <= ~chg[usel];
    end
  end
`else
  assign dskchg_n = 1'b1;
`endif

endmodule
